// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Holds the arbiter state encoding, master identifiers and the default bus timeout.
package wb_arb_pkg;

  localparam int unsigned TMO_CYC_DEFAULT = 64;
  localparam int unsigned TMO_CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_TMO  = 2'd3
  } arb_state_e;

  typedef enum logic {
    MST_0 = 1'b0,
    MST_1 = 1'b1
  } mst_e;

  // One master's request bundle, muxed as a whole onto the shared bus.
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
  } wb_req_t;

endpackage

// File: rtl/wb_arb_tmo.sv
// Bus timeout counter: counts cycles of an unacknowledged strobe and flags
// the terminal count TMO_CYC-1; synchronous active-high reset.
module wb_arb_tmo
  import wb_arb_pkg::*;
#(
  parameter int unsigned TMO_CYC = TMO_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [TMO_CNT_W-1:0] TC_VAL = TMO_CNT_W'(TMO_CYC - 1);

  logic [TMO_CNT_W-1:0] cnt_q;
  logic [TMO_CNT_W-1:0] cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TMO_CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter with per-tenure bus timeout.
// Master 0 (CPU) and master 1 (DMA) share one slave bus; grants are registered.
module wb_arb2
  import wb_arb_pkg::*;
#(
  parameter int unsigned TMO_CYC = TMO_CYC_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [15:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  input  logic [1:0]  m0_sel_i,
  output logic        m0_gnt_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [15:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  input  logic [1:0]  m1_sel_i,
  output logic        m1_gnt_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i,
  input  logic [15:0] wb_dat_i,

  output logic [15:0] m_dat_o,
  output logic        tmo_o,
  output logic        tmo_mst_o
);

  arb_state_e state_q, state_d;
  mst_e       ptr_q, ptr_d;
  mst_e       tmo_mst_q, tmo_mst_d;

  wb_req_t m0_req, m1_req, own_req;

  logic tmo_clr, tmo_en, tmo_tc, tmo_fire;

  assign m0_req = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                    adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i};
  assign m1_req = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                    adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i};

  // Only the owner's request reaches the slave; IDLE and TMO drive an all-zero bus.
  always_comb begin
    own_req = '0;
    if (state_q == ST_GNT0) begin
      own_req = m0_req;
    end else if (state_q == ST_GNT1) begin
      own_req = m1_req;
    end
  end

  // A pending strobe ages only while unacknowledged; an ack in the terminal cycle still wins.
  assign tmo_clr  = ~own_req.cyc | ~own_req.stb | wb_ack_i;
  assign tmo_en   = own_req.stb & ~wb_ack_i;
  assign tmo_fire = tmo_tc & own_req.cyc & own_req.stb & ~wb_ack_i;

  wb_arb_tmo #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tmo_mst_d = tmo_mst_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = (ptr_q == MST_1) ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc_i) begin
          state_d = ST_IDLE;
          ptr_d   = MST_0;
        end else if (tmo_fire) begin
          state_d   = ST_TMO;
          ptr_d     = MST_0;
          tmo_mst_d = MST_0;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i) begin
          state_d = ST_IDLE;
          ptr_d   = MST_1;
        end else if (tmo_fire) begin
          state_d   = ST_TMO;
          ptr_d     = MST_1;
          tmo_mst_d = MST_1;
        end
      end
      ST_TMO: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pointer resets to master 1 so master 0 wins the first contended arbitration.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= MST_1;
      tmo_mst_q <= MST_0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tmo_mst_q <= tmo_mst_d;
    end
  end

  assign m0_gnt_o = (state_q == ST_GNT0);
  assign m1_gnt_o = (state_q == ST_GNT1);
  assign m0_ack_o = wb_ack_i & m0_gnt_o;
  assign m1_ack_o = wb_ack_i & m1_gnt_o;

  assign tmo_o     = (state_q == ST_TMO);
  assign tmo_mst_o = tmo_o & (tmo_mst_q == MST_1);
  assign m0_err_o  = tmo_o & (tmo_mst_q == MST_0);
  assign m1_err_o  = tmo_o & (tmo_mst_q == MST_1);

  assign wb_cyc_o = own_req.cyc;
  assign wb_stb_o = own_req.stb;
  assign wb_we_o  = own_req.we;
  assign wb_adr_o = own_req.adr;
  assign wb_dat_o = own_req.dat;
  assign wb_sel_o = own_req.sel;
  assign m_dat_o  = wb_dat_i;

endmodule
